// File: rtl/clk_step_controller.sv
// Clock-enable controller for the 16-bit RISC core.
// A programmable prescaler on clk_in produces a one-cycle tick. A small FSM
// turns ticks into cpu_en pulses for continuous run or debounced single-step,
// or holds the core in HALT. Everything runs in the clk_in domain.
module clk_step_controller #(
  parameter int unsigned DIV_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 200000,
  parameter int unsigned DEB_TICKS      = 20,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 mode_run,
  input  logic                 step_btn,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] step_count
);

  localparam int unsigned DEB_W = (DEB_TICKS > 2) ? $clog2(DEB_TICKS) : 1;

  localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEB_TICKS - 1);
  localparam logic [DEB_W-1:0]     DEB_ONE    = DEB_W'(1);
  localparam logic [DIV_WIDTH-1:0] PERIOD_RST = DIV_WIDTH'(DEFAULT_PERIOD);
  localparam logic [DIV_WIDTH-1:0] PERIOD_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Prescaler
  logic [DIV_WIDTH-1:0] r_period;
  logic [DIV_WIDTH-1:0] r_presc;
  logic [DIV_WIDTH-1:0] w_period_load;
  logic                 w_terminal;
  logic                 w_tick;

  // Step button synchronizer and debounce
  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             w_step_evt;

  // FSM and outputs
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_pulse;
  logic                 r_cpu_en;
  logic [CNT_WIDTH-1:0] r_step_count;

  // Periods below 2 cannot produce a distinct tick, so they are clamped.
  assign w_period_load = (div_value < PERIOD_MIN) ? PERIOD_MIN : div_value;
  assign w_terminal    = (r_presc == (r_period - DIV_ONE));
  // A load in the terminal cycle wins: the tick is withheld and the count restarts.
  assign w_tick        = w_terminal & ~div_load;

  // Prescaler counter and period register; a load restarts the count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_period <= PERIOD_RST;
      r_presc  <= '0;
    end else if (div_load) begin
      r_period <= w_period_load;
      r_presc  <= '0;
    end else if (w_terminal) begin
      r_presc  <= '0;
    end else begin
      r_presc  <= r_presc + DIV_ONE;
    end
  end

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Tick-sampled debounce: accept a new level after DEB_TICKS differing ticks.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_stable  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (w_tick) begin
      if (r_sync2 == r_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_stable  <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_ONE;
      end
    end
  end

  // Step event fires in the same cycle the stable level is accepted as 1,
  // which avoids an extra edge-detect flop and a cycle of latency.
  assign w_step_evt = w_tick & r_sync2 & ~r_stable & (r_deb_cnt == DEB_LAST);

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and pulse request; priority halt_req > mode_run > step_evt.
  always_comb begin
    w_state_next = r_state;
    w_pulse      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end else if (mode_run) begin
          w_state_next = ST_RUN;
        end else if (w_step_evt) begin
          w_state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end else if (!mode_run) begin
          w_state_next = ST_IDLE;
        end else begin
          w_pulse = w_tick;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end else if (w_tick) begin
          w_pulse      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Registered clock enable, one cycle after the qualifying tick.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cpu_en <= 1'b0;
    end else begin
      r_cpu_en <= w_pulse;
    end
  end

  // Count issued enables; wraps naturally, cleared only by reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_step_count <= '0;
    end else if (r_cpu_en) begin
      r_step_count <= r_step_count + CNT_ONE;
    end
  end

  assign tick       = w_tick;
  assign cpu_en     = r_cpu_en;
  assign state      = r_state;
  assign step_count = r_step_count;

endmodule
